// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between fetch (I) and data (D) requesters.
// One transaction in flight; commands are registered, responses are routed back to the owner.
module mem_arbiter #(
    parameter int WORD_LEN = 32,
    parameter int ADDR_LEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_req_valid,
    output logic                i_req_ready,
    input  logic [ADDR_LEN-1:0] i_req_addr,
    output logic                i_resp_valid,
    output logic [WORD_LEN-1:0] i_resp_rdata,
    input  logic                d_req_valid,
    output logic                d_req_ready,
    input  logic [ADDR_LEN-1:0] d_req_addr,
    input  logic                d_req_wen,
    input  logic [WORD_LEN-1:0] d_req_wdata,
    output logic                d_resp_valid,
    output logic [WORD_LEN-1:0] d_resp_rdata,
    output logic                mem_cmd_valid,
    input  logic                mem_cmd_ready,
    output logic [ADDR_LEN-1:0] mem_cmd_addr,
    output logic                mem_cmd_wen,
    output logic [WORD_LEN-1:0] mem_cmd_wdata,
    input  logic                mem_resp_valid,
    input  logic [WORD_LEN-1:0] mem_resp_rdata,
    output logic                busy
);

    typedef enum logic [1:0] {IDLE, CMD, WAIT} state_t;
    localparam logic OWN_D = 1'b0;
    localparam logic OWN_I = 1'b1;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_grant_q, last_grant_d;
    logic                cmd_valid_q, cmd_valid_d;
    logic [ADDR_LEN-1:0] cmd_addr_q, cmd_addr_d;
    logic                cmd_wen_q, cmd_wen_d;
    logic [WORD_LEN-1:0] cmd_wdata_q, cmd_wdata_d;
    logic                grant_i, grant_d;

    // Under contention the side that did not win last time goes first.
    assign grant_i = i_req_valid & (~d_req_valid | (last_grant_q == OWN_D));
    assign grant_d = d_req_valid & (~i_req_valid | (last_grant_q == OWN_I));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= OWN_D;
            last_grant_q <= OWN_D;
            cmd_valid_q  <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_wen_q    <= 1'b0;
            cmd_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_wen_q    <= cmd_wen_d;
            cmd_wdata_q  <= cmd_wdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cmd_valid_d  = cmd_valid_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_wen_d    = cmd_wen_q;
        cmd_wdata_d  = cmd_wdata_q;
        case (state_q)
            IDLE: begin
                if (grant_i) begin
                    state_d      = CMD;
                    owner_d      = OWN_I;
                    last_grant_d = OWN_I;
                    cmd_valid_d  = 1'b1;
                    cmd_addr_d   = i_req_addr;
                    cmd_wen_d    = 1'b0;
                    cmd_wdata_d  = '0;
                end else if (grant_d) begin
                    state_d      = CMD;
                    owner_d      = OWN_D;
                    last_grant_d = OWN_D;
                    cmd_valid_d  = 1'b1;
                    cmd_addr_d   = d_req_addr;
                    cmd_wen_d    = d_req_wen;
                    cmd_wdata_d  = d_req_wdata;
                end
            end
            CMD: begin
                if (mem_cmd_ready) begin
                    state_d     = WAIT;
                    cmd_valid_d = 1'b0;
                end
            end
            WAIT: begin
                if (mem_resp_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        i_req_ready  = (state_q == IDLE) & grant_i;
        d_req_ready  = (state_q == IDLE) & ~grant_i & grant_d;
        i_resp_valid = (state_q == WAIT) & mem_resp_valid & (owner_q == OWN_I);
        d_resp_valid = (state_q == WAIT) & mem_resp_valid & (owner_q == OWN_D);
        busy         = (state_q != IDLE);
    end

    assign i_resp_rdata  = mem_resp_rdata;
    assign d_resp_rdata  = mem_resp_rdata;
    assign mem_cmd_valid = cmd_valid_q;
    assign mem_cmd_addr  = cmd_addr_q;
    assign mem_cmd_wen   = cmd_wen_q;
    assign mem_cmd_wdata = cmd_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scenario bench for mem_arbiter; response strobes are matched against a scoreboard queue.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req_valid, i_req_ready, i_resp_valid;
    logic [31:0] i_req_addr, i_resp_rdata;
    logic        d_req_valid, d_req_ready, d_req_wen, d_resp_valid;
    logic [31:0] d_req_addr, d_req_wdata, d_resp_rdata;
    logic        mem_cmd_valid, mem_cmd_ready, mem_cmd_wen, mem_resp_valid, busy;
    logic [31:0] mem_cmd_addr, mem_cmd_wdata, mem_resp_rdata;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit          side_i;
        bit          chk_data;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    mem_arbiter #(.WORD_LEN(32), .ADDR_LEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
        .i_resp_valid(i_resp_valid), .i_resp_rdata(i_resp_rdata),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
        .d_req_wen(d_req_wen), .d_req_wdata(d_req_wdata),
        .d_resp_valid(d_resp_valid), .d_resp_rdata(d_resp_rdata),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_addr(mem_cmd_addr),
        .mem_cmd_wen(mem_cmd_wen), .mem_cmd_wdata(mem_cmd_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Scoreboard: every response strobe must match the oldest expected entry.
    always @(negedge clk) begin
        if (i_resp_valid || d_resp_valid) begin
            exp_t e;
            checks++;
            if (i_resp_valid && d_resp_valid) begin
                failures++;
                $display("FAIL sb_both_strobes: i=%0b d=%0b required one-hot", i_resp_valid, d_resp_valid);
            end else if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: i=%0b d=%0b with no response expected", i_resp_valid, d_resp_valid);
            end else begin
                e = exp_q.pop_front();
                if (i_resp_valid !== e.side_i) begin
                    failures++;
                    $display("FAIL sb_side: i_resp_valid=%0b required %0b", i_resp_valid, e.side_i);
                end else if (e.chk_data && ((e.side_i ? i_resp_rdata : d_resp_rdata) !== e.data)) begin
                    failures++;
                    $display("FAIL sb_data: got %h required %h", e.side_i ? i_resp_rdata : d_resp_rdata, e.data);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        i_req_valid = 0; i_req_addr = 0;
        d_req_valid = 0; d_req_addr = 0; d_req_wen = 0; d_req_wdata = 0;
        mem_cmd_ready = 0; mem_resp_valid = 0; mem_resp_rdata = 0;
        cyc();
        cyc();
        rst_n = 1'b1;
        #1;
    endtask

    // Command acceptance with memory ready at once, response the cycle after.
    task automatic finish_txn(input logic [31:0] rdata);
        mem_cmd_ready = 1'b1;
        cyc();
        mem_cmd_ready = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = rdata;
        cyc();
        mem_resp_valid = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        rst_n = 1'b0;
        mem_resp_valid = 1'b1;
        #1;
        checks++;
        if ({busy, mem_cmd_valid, mem_cmd_wen, i_req_ready, d_req_ready, i_resp_valid, d_resp_valid} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctrl: busy=%0b cmdv=%0b wen=%0b ir=%0b dr=%0b iv=%0b dv=%0b required all 0",
                     busy, mem_cmd_valid, mem_cmd_wen, i_req_ready, d_req_ready, i_resp_valid, d_resp_valid);
        end
        checks++;
        if (mem_cmd_addr !== 32'h0 || mem_cmd_wdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_data: addr=%h wdata=%h required 0", mem_cmd_addr, mem_cmd_wdata);
        end
        mem_resp_valid = 1'b0;
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_single_fetch();
        i_req_valid = 1'b1;
        i_req_addr = 32'h8;
        #1;
        checks++;
        if (i_req_ready !== 1'b1 || d_req_ready !== 1'b0) begin
            failures++;
            $display("FAIL fetch_ready: i=%0b d=%0b required 1 0", i_req_ready, d_req_ready);
        end
        exp_q.push_back('{side_i: 1'b1, chk_data: 1'b1, data: 32'h00002003});
        cyc();
        i_req_valid = 1'b0;
        i_req_addr = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (mem_cmd_valid !== 1'b1 || mem_cmd_addr !== 32'h8 || mem_cmd_wen !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL fetch_cmd: v=%0b addr=%h wen=%0b busy=%0b required 1 00000008 0 1",
                     mem_cmd_valid, mem_cmd_addr, mem_cmd_wen, busy);
        end
        mem_cmd_ready = 1'b1;
        cyc();
        mem_cmd_ready = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h00002003;
        #1;
        checks++;
        if (i_resp_valid !== 1'b1 || d_resp_valid !== 1'b0 || mem_cmd_valid !== 1'b0) begin
            failures++;
            $display("FAIL fetch_resp: iv=%0b dv=%0b cmdv=%0b required 1 0 0", i_resp_valid, d_resp_valid, mem_cmd_valid);
        end
        cyc();
        mem_resp_valid = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL fetch_idle: busy=%0b required 0", busy);
        end
    endtask

    task automatic test_contention();
        apply_reset();
        i_req_valid = 1'b1; i_req_addr = 32'h0;
        d_req_valid = 1'b1; d_req_addr = 32'h100; d_req_wen = 1'b0; d_req_wdata = 32'h0;
        for (int t = 0; t < 4; t++) begin
            bit exp_i;
            int n;
            exp_i = (t % 2 == 0);
            n = 0;
            #1;
            while (!(i_req_ready || d_req_ready) && n < 10) begin
                cyc();
                #1;
                n++;
            end
            checks++;
            if (i_req_ready !== exp_i || d_req_ready !== !exp_i) begin
                failures++;
                $display("FAIL contention_grant%0d: i=%0b d=%0b required %0b %0b", t, i_req_ready, d_req_ready, exp_i, !exp_i);
            end
            exp_q.push_back('{side_i: exp_i, chk_data: 1'b1, data: 32'hA000 + t});
            cyc();
            checks++;
            if (mem_cmd_addr !== (exp_i ? 32'h0 : 32'h100) || mem_cmd_valid !== 1'b1) begin
                failures++;
                $display("FAIL contention_addr%0d: addr=%h v=%0b required %h 1", t, mem_cmd_addr, mem_cmd_valid,
                         exp_i ? 32'h0 : 32'h100);
            end
            finish_txn(32'hA000 + t);
        end
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        cyc();
    endtask

    task automatic test_write_stall();
        d_req_valid = 1'b1; d_req_wen = 1'b1; d_req_addr = 32'h40; d_req_wdata = 32'hDEADBEEF;
        #1;
        checks++;
        if (d_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL write_ready: d=%0b required 1", d_req_ready);
        end
        exp_q.push_back('{side_i: 1'b0, chk_data: 1'b0, data: 32'h0});
        cyc();
        d_req_valid = 1'b0; d_req_wen = 1'b0; d_req_addr = 32'h0; d_req_wdata = 32'h0;
        i_req_valid = 1'b1; i_req_addr = 32'h44;
        for (int k = 0; k < 4; k++) begin
            mem_cmd_ready = (k == 3);
            #1;
            checks++;
            if (mem_cmd_valid !== 1'b1 || mem_cmd_addr !== 32'h40 || mem_cmd_wen !== 1'b1 ||
                mem_cmd_wdata !== 32'hDEADBEEF || i_req_ready !== 1'b0) begin
                failures++;
                $display("FAIL write_hold%0d: v=%0b addr=%h wen=%0b wdata=%h ir=%0b required 1 00000040 1 deadbeef 0",
                         k, mem_cmd_valid, mem_cmd_addr, mem_cmd_wen, mem_cmd_wdata, i_req_ready);
            end
            cyc();
        end
        mem_cmd_ready = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'h1234;
        #1;
        checks++;
        if (d_resp_valid !== 1'b1 || i_req_ready !== 1'b0 || mem_cmd_valid !== 1'b0) begin
            failures++;
            $display("FAIL write_ack: dv=%0b ir=%0b cmdv=%0b required 1 0 0", d_resp_valid, i_req_ready, mem_cmd_valid);
        end
        cyc();
        mem_resp_valid = 1'b0;
        i_req_valid = 1'b0;
        cyc();
    endtask

    task automatic test_spurious();
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'hBAD0;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if (i_resp_valid !== 1'b0 || d_resp_valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL spurious_idle%0d: iv=%0b dv=%0b busy=%0b required 0 0 0", k, i_resp_valid, d_resp_valid, busy);
            end
            cyc();
        end
        mem_resp_valid = 1'b0;
        i_req_valid = 1'b1;
        i_req_addr = 32'h30;
        cyc();
        i_req_valid = 1'b0;
        mem_resp_valid = 1'b1;
        cyc();
        mem_resp_valid = 1'b0;
        #1;
        checks++;
        if (mem_cmd_valid !== 1'b1 || busy !== 1'b1 || mem_cmd_addr !== 32'h30) begin
            failures++;
            $display("FAIL spurious_cmd: cmdv=%0b busy=%0b addr=%h required 1 1 00000030", mem_cmd_valid, busy, mem_cmd_addr);
        end
        exp_q.push_back('{side_i: 1'b1, chk_data: 1'b1, data: 32'h5A5A});
        finish_txn(32'h5A5A);
        cyc();
    endtask

    task automatic test_reset_wait();
        d_req_valid = 1'b1; d_req_addr = 32'h200; d_req_wen = 1'b0;
        cyc();
        d_req_valid = 1'b0;
        mem_cmd_ready = 1'b1;
        cyc();
        mem_cmd_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || mem_cmd_valid !== 1'b0) begin
            failures++;
            $display("FAIL rstwait_async: busy=%0b cmdv=%0b required 0 0", busy, mem_cmd_valid);
        end
        cyc();
        rst_n = 1'b1;
        cyc();
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'hDEAD;
        #1;
        checks++;
        if (i_resp_valid !== 1'b0 || d_resp_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rstwait_late: iv=%0b dv=%0b busy=%0b required 0 0 0", i_resp_valid, d_resp_valid, busy);
        end
        cyc();
        mem_resp_valid = 1'b0;
        d_req_valid = 1'b1; d_req_addr = 32'h204;
        #1;
        checks++;
        if (d_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL rstwait_next: d_req_ready=%0b required 1", d_req_ready);
        end
        exp_q.push_back('{side_i: 1'b0, chk_data: 1'b1, data: 32'h7777});
        cyc();
        d_req_valid = 1'b0;
        finish_txn(32'h7777);
        cyc();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_contention();
        test_write_stall();
        test_spurious();
        test_reset_wait();
        repeat (2) cyc();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: %0d responses outstanding, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
